// File: rtl/dvp_rgb565_capture.sv
// DVP byte-pair to RGB565 capture with post-configuration frame skipping
// and per-line / per-frame resolution checking, all in the pixel clock domain.
module dvp_rgb565_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10,
    parameter int BYTE_ORDER  = 0
) (
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic        cam_init_done,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_db,
    output logic        vsync,
    output logic        de,
    output logic [15:0] data_rgb565,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_SKIP      = 2'd1,
        ST_CAPTURE   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  skip_cnt_reg, skip_cnt_next;
    logic        vs_r, vs_d, hr_r, hr_d;
    logic [7:0]  db_r;
    logic        phase_reg;
    logic [7:0]  first_byte_reg;
    logic [11:0] pix_cnt_reg, line_cnt_reg;
    logic [11:0] pix_inc, line_inc, line_cnt_eff;
    logic [15:0] pixel_word;
    logic        vs_rise, hr_fall, cap_next, pixel_strobe;

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            vs_r <= 1'b0;
            vs_d <= 1'b0;
            hr_r <= 1'b0;
            hr_d <= 1'b0;
            db_r <= 8'd0;
        end else begin
            vs_r <= cmos_vsync;
            vs_d <= vs_r;
            hr_r <= cmos_href;
            hr_d <= hr_r;
            db_r <= cmos_db;
        end
    end

    assign vs_rise = vs_r & ~vs_d;
    assign hr_fall = ~hr_r & hr_d;

    always_comb begin
        state_next    = state_reg;
        skip_cnt_next = skip_cnt_reg;
        if (!cam_init_done) begin
            state_next = ST_WAIT_INIT;
        end else begin
            case (state_reg)
                ST_WAIT_INIT: begin
                    if (vs_rise) begin
                        skip_cnt_next = 8'd0;
                        state_next    = (SKIP_FRAMES == 0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (vs_rise) begin
                        skip_cnt_next = skip_cnt_reg + 8'd1;
                        if (skip_cnt_reg + 8'd1 == 8'(SKIP_FRAMES))
                            state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: state_next = ST_CAPTURE;
                default:    state_next = ST_WAIT_INIT;
            endcase
        end
    end

    // Gating on the next state lets an init drop blank outputs at the very next edge
    // and lets the entry frame-sync pulse through in full.
    assign cap_next     = (state_next == ST_CAPTURE);
    assign pixel_strobe = hr_r & phase_reg;

    generate
        if (BYTE_ORDER == 0) begin : g_first_msb
            assign pixel_word = {first_byte_reg, db_r};
        end else begin : g_first_lsb
            assign pixel_word = {db_r, first_byte_reg};
        end
    endgenerate

    assign pix_inc      = (pix_cnt_reg == 12'hFFF) ? pix_cnt_reg : pix_cnt_reg + 12'd1;
    assign line_inc     = (line_cnt_reg == 12'hFFF) ? line_cnt_reg : line_cnt_reg + 12'd1;
    // A line ending on the same edge as the frame sync is counted before the frame check.
    assign line_cnt_eff = hr_fall ? line_inc : line_cnt_reg;

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            state_reg      <= ST_WAIT_INIT;
            skip_cnt_reg   <= 8'd0;
            phase_reg      <= 1'b0;
            first_byte_reg <= 8'd0;
            pix_cnt_reg    <= 12'd0;
            line_cnt_reg   <= 12'd0;
            vsync          <= 1'b0;
            de             <= 1'b0;
            data_rgb565    <= 16'd0;
            frame_done     <= 1'b0;
            line_err       <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            skip_cnt_reg <= skip_cnt_next;
            phase_reg    <= hr_r ? ~phase_reg : 1'b0;
            if (hr_r && !phase_reg)
                first_byte_reg <= db_r;
            de <= pixel_strobe & cap_next;
            if (pixel_strobe && cap_next)
                data_rgb565 <= pixel_word;
            vsync      <= vs_r & cap_next;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (!cap_next) begin
                pix_cnt_reg  <= 12'd0;
                line_cnt_reg <= 12'd0;
            end else begin
                if (hr_fall)
                    pix_cnt_reg <= 12'd0;
                else if (pixel_strobe)
                    pix_cnt_reg <= pix_inc;
                // phase_reg still high at the falling edge means an odd byte was dropped.
                if (hr_fall)
                    line_err <= (pix_cnt_reg != 12'(H_ACTIVE)) | phase_reg;
                if (vs_rise && line_cnt_eff != 12'd0) begin
                    frame_done   <= 1'b1;
                    frame_err    <= (line_cnt_eff != 12'(V_ACTIVE));
                    line_cnt_reg <= 12'd0;
                end else begin
                    line_cnt_reg <= line_cnt_eff;
                end
            end
        end
    end

endmodule

// File: doc/dvp_rgb565_capture.md
# dvp_rgb565_capture

Pixel-clock-domain capture stage between the CMOS DVP pins and the camera user stream. Pairs 8-bit DVP bytes into RGB565 pixels and discards the first SKIP_FRAMES frames after sensor configuration. Drives the `vsync`/`de`/`data_rgb565` stream consumed by the UDP packetiser, and checks every line and frame against the configured resolution.

## Interface
- `H_ACTIVE`, 640: expected pixels per line.
- `V_ACTIVE`, 480: expected lines per frame.
- `SKIP_FRAMES`, 10: complete frames discarded after arming (0 allowed).
- `BYTE_ORDER`, 0: 0 means the first byte of a pair is `data_rgb565[15:8]`; 1 means it is `[7:0]`.
- `cmos_pclk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cam_init_done`  in  1  SCCB configuration complete; capture is armed only while high.
- `cmos_vsync`  in  1  active-high frame sync.
- `cmos_href`  in  1  line valid.
- `cmos_db`  in  8  DVP data.
- `vsync`  out  1  registered frame sync, passed only in CAPTURE.
- `de`  out  1  one-cycle strobe per assembled pixel.
- `data_rgb565`  out  16  pixel; valid when `de`=1, holds its last value otherwise.
- `frame_done`  out  1  one-cycle pulse when a captured frame ends.
- `line_err`  out  1  one-cycle pulse on a bad line.
- `frame_err`  out  1  one-cycle pulse on a bad frame.

## Operation
- **Input stage.** `cmos_vsync`, `cmos_href` and `cmos_db` are registered once as `vs_r`, `hr_r` and `db_r`, plus one delayed copy of each of `vs_r` and `hr_r`.
  - `vs_rise` = `vs_r` and not its delayed copy.
  - `hr_fall` = not `hr_r` and its delayed copy.
- **State machine.**
  - WAIT_INIT: on `vs_rise` with `cam_init_done`=1, go to SKIP with `skip_cnt`=0. If SKIP_FRAMES=0, go directly to CAPTURE.
  - SKIP: each `vs_rise` increments `skip_cnt`. When the incremented value equals SKIP_FRAMES, go to CAPTURE.
  - CAPTURE: remain until `cam_init_done`=0 or reset.
  - In any state, `cam_init_done`=0 forces WAIT_INIT on the next edge.
- **Byte pairing.**
  - `phase` toggles on every cycle with `hr_r`=1, and is cleared when `hr_r`=0.
  - On phase 0, `db_r` is latched as the first byte.
  - On phase 1, the pixel is formed per BYTE_ORDER, and `de` is registered high for one cycle if the state is CAPTURE.
  - A trailing odd byte is dropped and flags an odd line.
- **Line check (CAPTURE only), on `hr_fall`:**
  - `line_err` pulses if `pix_cnt` ≠ H_ACTIVE or the line had an odd byte count.
  - `line_cnt` increments; `pix_cnt` and the odd flag clear.
- **Frame check (CAPTURE only), on `vs_rise` with `line_cnt` > 0:**
  - `frame_done` pulses.
  - `frame_err` additionally pulses if `line_cnt` ≠ V_ACTIVE.
  - `line_cnt` clears.
  - The entry edge into CAPTURE produces no `frame_done`, because `line_cnt` is 0.
- **Counters.** `pix_cnt` and `line_cnt` are 12-bit and saturate at 4095; they never wrap. `skip_cnt` is 8-bit.
- **Vsync output.** `vsync` <= `vs_r` AND (next state == CAPTURE). The frame-sync pulse that triggers entry into CAPTURE is therefore passed on in full.
- **Reset.**
  - All outputs are 0, state is WAIT_INIT, and all counters and the phase are 0.
  - Reset asserted mid-line or mid-frame takes effect on the next edge. No partial pixel, `frame_done` or error pulse is emitted afterwards.

## Timing
- Pixel latency: the second byte sampled from the pins at edge k gives `de`/`data_rgb565` registered at edge k+1. Latency is 2 edges pin-to-output.
- `vsync` has the same 2-edge latency as `de`; `vsync` and `de` stay aligned to each other.
- Error and `frame_done` pulses are registered at the edge after the detected edge of `hr_r` or `vs_r`.
- At most one `de` every 2 cycles. There is no back-pressure; the downstream stage must accept every `de`.
- `cam_init_done` falling: `de` and `vsync` are 0 from the next edge.
- Simultaneous `vs_rise` and `hr_fall`: the line is counted first, then the frame check uses the incremented `line_cnt`.

## Test plan
- **Reset mid-line:** assert `rst_n`=0 during phase 1 of a CAPTURE line → at the next edge all outputs are 0 and the state is WAIT_INIT. After release, nothing is output until a new `vs_rise` arrives.
- **Skip count:** H_ACTIVE=4, V_ACTIVE=3, SKIP_FRAMES=2, `cam_init_done`=1, five `vs_rise` edges framing 4 frames of 3 lines × 8 bytes → frames 1–2 produce 0 `de`. Frames 3 and 4 produce 12 `de` each, `frame_done` pulses 2 times, and `line_err`/`frame_err` stay 0.
- **Byte order:** bytes 0xF8 then 0x1F → `data_rgb565`=0xF81F with BYTE_ORDER=0, and 0x1FF8 with BYTE_ORDER=1, 2 edges after 0x1F is on the pins.
- **Bad line and frame:** in CAPTURE, one line of 6 bytes, and separately one line of 9 bytes → 3 `de` plus 1 `line_err` for the first; 4 `de` plus 1 `line_err` for the second. A frame of 2 full lines → `frame_done` and `frame_err` pulse together at the next `vs_rise`.
- **Init drop:** deassert `cam_init_done` mid-frame → `de`=0 from the next edge. After reassertion, SKIP_FRAMES frames are discarded again before output resumes.
- **Saturation:** hold `cmos_href` high for 10000 bytes → `pix_cnt` holds at 4095 and `line_err` pulses once at `hr_fall`.
